t_counter: RTL and testbench
============================

// Module: t_counter
//
// PURPOSE
// - Synchronous N-bit up/down counter built as a bank of T-type stages.
// - Each stage toggles when its computed T term is high.
// - Sits directly downstream of the T flip-flop cell: it generates the
//   per-bit T vector, applies it on the clock edge, and exports the vector
//   so downstream logic can watch bit activity.
// - Provides modulo wrap, parallel load and a terminal-count flag.
//
// PARAMETERS
// - WIDTH      4                counter width in bits (>= 2)
// - MAX_COUNT  (1<<WIDTH)-1     highest count value; count range is 0..MAX_COUNT
//
// PORTS
// - clock     input   1      rising-edge clock; single clock domain
// - reset_n   input   1      synchronous, active-low reset
// - en        input   1      count enable
// - up_dn     input   1      1 = count up, 0 = count down
// - load      input   1      parallel load strobe
// - load_val  input   WIDTH  value taken on load
// - count     output  WIDTH  registered count
// - toggle    output  WIDTH  T vector applied this cycle (count_next ^ count)
// - tc        output  1      terminal count (combinational)
//
// BEHAVIOUR
// - Reset:
//   - Synchronous, active-low; sampled only on the rising edge of clock.
//   - reset_n=0 at an edge -> count=0 on that edge.
//   - While reset_n=0: toggle=0 and tc=0, whatever the other inputs are.
// - Priority at each edge: reset_n=0 > load=1 > en=1 > hold.
// - Load:
//   - count <= load_val, with a one-cycle latency.
//   - load_val > MAX_COUNT is clamped to MAX_COUNT.
//   - Load ignores en and up_dn.
// - Count up (en=1, up_dn=1):
//   - count <= count+1.
//   - At count==MAX_COUNT: count <= 0 (wrap).
// - Count down (en=1, up_dn=0):
//   - count <= count-1.
//   - At count==0: count <= MAX_COUNT (wrap).
// - Hold: en=0 and load=0 -> count unchanged, toggle=0.
// - T vector:
//   - toggle = count_next ^ count, computed combinationally from the current
//     inputs.
//   - For a power-of-two range, counting up gives
//     toggle[i] = en & (&count[i-1:0]); counting down gives
//     toggle[i] = en & ~(|count[i-1:0]); toggle[0] = en.
//   - At a non-power-of-two wrap the wrap value overrides those terms; toggle
//     is still exactly count_next ^ count.
// - Terminal count:
//   - tc = reset_n & en & ~load & (up_dn ? count==MAX_COUNT : count==0).
// - Arithmetic:
//   - All compares and increments are WIDTH bits, unsigned.
//   - No intermediate carry-out is exposed.
// - Boundary cases:
//   - Direction change mid-count takes effect on the next edge; there is no
//     extra latency.
//   - load and en both high at the wrap point: load wins, and tc=0.
//   - reset_n deasserted: counting starts on the first edge with reset_n=1
//     and en=1.
//   - No state other than count; there are no hidden pipeline stages.
//
// CONFIGURATION
// - Macro: T_COUNTER_SATURATE_EN
// - Defined:
//   - Counting up at MAX_COUNT holds at MAX_COUNT.
//   - Counting down at 0 holds at 0.
//   - toggle=0 in those cycles; tc still asserts by the same equation.
// - Undefined (default): modulo wrap as described in BEHAVIOUR.
//
// TESTING (WIDTH=4, 10-unit clock period unless noted)
// 1. Hold reset_n=0 for 2 edges, then release; en=1, up_dn=1 for 16 edges
//    -> count 0,1,..,15,0; tc=1 only while count=15; toggle=4'b1111 on
//    15->0 and 4'b0001 on 0->1.
// 2. At count=0, set up_dn=0 and en=1 -> count 15,14,..; tc=1 at count=0
//    before the wrap; toggle=4'b1111 on 0->15.
// 3. MAX_COUNT=9: count up from 7 -> 8,9,0; toggle on 9->0 = 4'b1001.
//    Then load=1 with load_val=12 -> count=9 (clamped).
// 4. At count=15 with en=1: apply load=1, load_val=5 together with reset_n=0
//    -> count=0. Repeat with reset_n=1 -> count=5 and tc=0 during the load
//    cycle.
// 5. en=0 for 3 edges with up_dn toggling -> count stable, toggle=0, tc=0.
// 6. T_COUNTER_SATURATE_EN defined: count up past 15 -> stays at 15 with
//    toggle=0 and tc=1. Count down past 0 -> stays at 0.

Source files
------------

// File: rtl/t_counter.sv
// rtl/t_counter.sv - synchronous up/down counter built as a bank of T stages, exporting its T vector
// Optional feature: define T_COUNTER_SATURATE_EN to hold at the range ends instead of wrapping.
module t_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_toggle,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] LP_MAX  = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef T_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] LP_UP_END = LP_MAX;
  localparam logic [WIDTH-1:0] LP_DN_END = LP_ZERO;
`else
  localparam logic [WIDTH-1:0] LP_UP_END = LP_ZERO;
  localparam logic [WIDTH-1:0] LP_DN_END = LP_MAX;
`endif

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_zero;

  always_comb begin
    w_at_max   = (r_count == LP_MAX);
    w_at_zero  = (r_count == LP_ZERO);
    w_load_val = (i_load_val > LP_MAX) ? LP_MAX : i_load_val;
    w_next     = r_count;
    if (i_load) begin
      w_next = w_load_val;
    end else if (i_en) begin
      if (i_up_dn) begin
        w_next = w_at_max ? LP_UP_END : r_count + LP_ONE;
      end else begin
        w_next = w_at_zero ? LP_DN_END : r_count - LP_ONE;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  // The T vector is whatever flips this edge, so wrap/saturate overrides come for free.
  assign o_toggle = i_reset_n ? (w_next ^ r_count) : '0;
  assign o_tc     = i_reset_n & i_en & ~i_load & (i_up_dn ? w_at_max : w_at_zero);
  assign o_count  = r_count;

endmodule

// File: tb/tb_t_counter.sv
// tb/tb_t_counter.sv - bench for t_counter, full range and MAX_COUNT=9 instances against a modular-arithmetic model
module tb_t_counter;

`ifdef T_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] cnt15, tog15, cnt9, tog9;
  logic       tc15, tc9;

  int errors = 0;
  int checks = 0;
  int m15 = 0;
  int m9 = 0;

  always #5 clk = ~clk;

  t_counter #(.WIDTH(4)) u_full (
    .i_clock(clk), .i_reset_n(reset_n), .i_en(en), .i_up_dn(up_dn),
    .i_load(load), .i_load_val(load_val),
    .o_count(cnt15), .o_toggle(tog15), .o_tc(tc15)
  );

  t_counter #(.WIDTH(4), .MAX_COUNT(9)) u_dec (
    .i_clock(clk), .i_reset_n(reset_n), .i_en(en), .i_up_dn(up_dn),
    .i_load(load), .i_load_val(load_val),
    .o_count(cnt9), .o_toggle(tog9), .o_tc(tc9)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next count from the range rules: values live in 0..mx, steps are modulo mx+1.
  function automatic int model_next(int m, int mx, bit rst, bit ld, int lv, bit e, bit up);
    if (!rst) return 0;
    if (ld) return (lv > mx) ? mx : lv;
    if (!e) return m;
    if (up) return (m == mx) ? (SAT ? mx : 0) : m + 1;
    return (m == 0) ? (SAT ? 0 : mx) : m - 1;
  endfunction

  function automatic int model_tc(int m, int mx, bit rst, bit ld, bit e, bit up);
    return (rst && e && !ld && (up ? (m == mx) : (m == 0))) ? 1 : 0;
  endfunction

  task automatic step(input bit rst, input bit e, input bit up, input bit ld, input int lv);
    int n15, n9;
    reset_n  = rst;
    en       = e;
    up_dn    = up;
    load     = ld;
    load_val = lv[3:0];
    #1;
    n15 = model_next(m15, 15, rst, ld, lv, e, up);
    n9  = model_next(m9, 9, rst, ld, lv, e, up);
    chk("toggle_full", {28'd0, tog15}, rst ? (n15 ^ m15) : 0);
    chk("tc_full", {31'd0, tc15}, model_tc(m15, 15, rst, ld, e, up));
    chk("toggle_mod9", {28'd0, tog9}, rst ? (n9 ^ m9) : 0);
    chk("tc_mod9", {31'd0, tc9}, model_tc(m9, 9, rst, ld, e, up));
    @(posedge clk);
    #1;
    m15 = n15;
    m9  = n9;
    chk("count_full", {28'd0, cnt15}, m15);
    chk("count_mod9", {28'd0, cnt9}, m9);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // reset for two edges, then count up through a full wrap
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 7);
    chk("reset_count", {28'd0, cnt15}, 0);
    for (int i = 0; i < 17; i++) step(1, 1, 1, 0, 0);
    // reverse at zero and count down across the wrap
    step(1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    // load 7, count up past 9
    step(1, 0, 0, 1, 7);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 12);
    chk("clamp_mod9", {28'd0, cnt9}, 9);
    // load versus reset at the terminal count
    step(1, 0, 1, 1, 15);
    step(0, 1, 1, 1, 5);
    chk("reset_over_load", {28'd0, cnt15}, 0);
    step(1, 0, 1, 1, 15);
    step(1, 1, 1, 1, 5);
    chk("load_over_wrap", {28'd0, cnt15}, 5);
    // hold with direction flipping
    for (int i = 0; i < 3; i++) step(1, 0, i[0], 0, 0);
    // run into both ends to exercise wrap or saturation
    step(1, 0, 1, 1, 14);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 15));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
